// File: rtl/muldiv_iter_unit_pkg.sv
// muldiv_iter_unit_pkg: width codes, funct3 op codes, FSM states and operand-signedness helpers
// shared by the iterative multiply/divide unit.
package muldiv_iter_unit_pkg;
   localparam logic [1:0] XLEN_32B = 2'd1;
   localparam logic [1:0] XLEN_64B = 2'd2;
   localparam logic [2:0] MD_OP_MUL    = 3'd0;
   localparam logic [2:0] MD_OP_MULH   = 3'd1;
   localparam logic [2:0] MD_OP_MULHSU = 3'd2;
   localparam logic [2:0] MD_OP_MULHU  = 3'd3;
   localparam logic [2:0] MD_OP_DIV    = 3'd4;
   localparam logic [2:0] MD_OP_DIVU   = 3'd5;
   localparam logic [2:0] MD_OP_REM    = 3'd6;
   localparam logic [2:0] MD_OP_REMU   = 3'd7;
   typedef enum logic [1:0] {MD_ST_IDLE = 2'd0, MD_ST_CALC = 2'd1, MD_ST_DONE = 2'd2} md_st_e;
   function automatic logic op_a_signed(input logic [2:0] op);
      return !(op == MD_OP_MUL || op == MD_OP_MULHU || op == MD_OP_DIVU || op == MD_OP_REMU);
   endfunction
   function automatic logic op_b_signed(input logic [2:0] op);
      return op_a_signed(op) && op != MD_OP_MULHSU;
   endfunction
endpackage

// File: rtl/md_div_core.sv
// md_div_core: one restoring-divide step; shifts the next dividend bit into the partial
// remainder, trial-subtracts the divisor and shifts the quotient bit in.
module md_div_core #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_rem,
   input  logic [W-1:0] i_quo,
   input  logic [W-1:0] i_div,
   output logic [W-1:0] o_rem,
   output logic [W-1:0] o_quo
);
   logic [W:0] sh, diff;
   always_comb begin
      sh = {i_rem, i_quo[W-1]};
      diff = sh - {1'b0, i_div};
      o_rem = diff[W] ? sh[W-1:0] : diff[W-1:0];
      o_quo = {i_quo[W-2:0], ~diff[W]};
   end
endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative RV M-extension unit, shift-add multiply and restoring divide at 1 bit/cycle.
// Define MULDIV_W_OPS_EN (64-bit only) to enable the RV64 *W forms via i_word.
module muldiv_iter_unit
   import muldiv_iter_unit_pkg::*;
#(
   parameter logic [1:0] XLEN      = XLEN_64B,
   parameter bit         FAST_ZERO = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [2:0]                    i_md_op,
   input  logic                          i_word,
   input  logic [(1<<(int'(XLEN)+4))-1:0] i_op_a,
   input  logic [(1<<(int'(XLEN)+4))-1:0] i_op_b,
   input  logic                          i_flush,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [(1<<(int'(XLEN)+4))-1:0] o_result,
   output logic                          o_busy
);
   localparam int W = 1 << (int'(XLEN) + 4);
   localparam int CW = $clog2(W);
   md_st_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2*W-1:0] p_q, p_d, p_n;
   logic [W-1:0] m_q, m_d, res_q, res_d, a_x, b_x, ma, mb, fast, dv, val, rem_n, quo_n;
   logic [W-1:0] prod_hi, unused_prod_lo;
   logic [W:0] sum;
   logic [2:0] op_q, op_d;
   logic neg_q, neg_d, word_q, word_d, word_in, sa, sb, b_zero, ovf;
`ifdef MULDIV_W_OPS_EN
   assign word_in = i_word;
   function automatic logic [W-1:0] sx(input logic [W-1:0] v, input logic w);
      return w ? {{(W-32){v[31]}}, v[31:0]} : v;
   endfunction
   function automatic logic [W-1:0] zx(input logic [W-1:0] v, input logic w);
      return w ? {{(W-32){1'b0}}, v[31:0]} : v;
   endfunction
`else
   logic unused_word;
   assign unused_word = i_word;
   assign word_in = 1'b0;
   function automatic logic [W-1:0] sx(input logic [W-1:0] v, input logic w);
      return w ? v : v;
   endfunction
   function automatic logic [W-1:0] zx(input logic [W-1:0] v, input logic w);
      return w ? v : v;
   endfunction
`endif
   md_div_core #(.W(W)) u_div (
      .i_rem(p_q[2*W-1:W]),
      .i_quo(p_q[W-1:0]),
      .i_div(m_q),
      .o_rem(rem_n),
      .o_quo(quo_n)
   );
   // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
   always_comb begin
      a_x = op_a_signed(i_md_op) ? sx(i_op_a, word_in) : zx(i_op_a, word_in);
      b_x = op_b_signed(i_md_op) ? sx(i_op_b, word_in) : zx(i_op_b, word_in);
      sa = op_a_signed(i_md_op) & a_x[W-1];
      sb = op_b_signed(i_md_op) & b_x[W-1];
      ma = sa ? -a_x : a_x;
      mb = sb ? -b_x : b_x;
      b_zero = b_x == '0;
      ovf = i_md_op[2] & op_b_signed(i_md_op) & (&b_x)
          & (a_x == (word_in ? sx(W'(32'h8000_0000), 1'b1) : {1'b1, {(W-1){1'b0}}}));
      fast = b_zero ? (i_md_op[1] ? a_x : '1) : (i_md_op[1] ? '0 : a_x);
      sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
      p_n = op_q[2] ? {rem_n, quo_n} : {sum, p_q[W-1:1]};
      {prod_hi, unused_prod_lo} = neg_q ? -p_n : p_n;
      dv = op_q[1] ? p_n[2*W-1:W] : p_n[W-1:0];
      val = op_q[2] ? (neg_q ? -dv : dv)
          : op_q == MD_OP_MUL ? (word_q ? p_n[W-1:0] >> 32 : p_n[W-1:0])
          : word_q ? '0 : prod_hi;
      state_d = state_q;
      cnt_d = cnt_q;
      p_d = p_q;
      m_d = m_q;
      res_d = res_q;
      op_d = op_q;
      neg_d = neg_q;
      word_d = word_q;
      if (state_q == MD_ST_IDLE && i_valid && !i_flush) begin
         op_d = i_md_op;
         word_d = word_in;
         neg_d = i_md_op[2] & i_md_op[1] ? sa : (sa ^ sb) & ~b_zero;
         m_d = i_md_op[2] ? mb : ma;
         p_d = {{W{1'b0}}, i_md_op[2] ? (word_in ? ma << 32 : ma) : mb};
         cnt_d = word_in ? CW'(31) : CW'(W-1);
         state_d = MD_ST_CALC;
         if (FAST_ZERO && i_md_op[2] && (b_zero || ovf)) begin
            res_d = sx(fast, word_in);
            state_d = MD_ST_DONE;
         end
      end else if (state_q == MD_ST_CALC) begin
         p_d = p_n;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) begin
            res_d = sx(val, word_q);
            state_d = MD_ST_DONE;
         end
      end else if (state_q == MD_ST_DONE && i_ready) begin
         state_d = MD_ST_IDLE;
      end
      if (i_flush) state_d = MD_ST_IDLE;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= MD_ST_IDLE;
         cnt_q <= '0;
         p_q <= '0;
         m_q <= '0;
         res_q <= '0;
         op_q <= '0;
         neg_q <= 1'b0;
         word_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         p_q <= p_d;
         m_q <= m_d;
         res_q <= res_d;
         op_q <= op_d;
         neg_q <= neg_d;
         word_q <= word_d;
      end
   end
   assign o_ready = state_q == MD_ST_IDLE;
   assign o_valid = state_q == MD_ST_DONE;
   assign o_busy = state_q != MD_ST_IDLE;
   assign o_result = res_q;
endmodule
